// File: rtl/menshen_pkt_arbiter.sv
// Packet-granular 2:1 AXI4-Stream arbiter: config (port 0) has priority over data (port 1),
// with a burst guard so data is not starved, and a hold input that blocks new data grants.
module menshen_pkt_arbiter #(
  parameter int DATA_W    = 512,
  parameter int USER_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                axis_aclk,
  input  logic                axis_aresetn,
  input  logic [DATA_W-1:0]   s_cfg_tdata,
  input  logic [DATA_W/8-1:0] s_cfg_tkeep,
  input  logic [USER_W-1:0]   s_cfg_tuser,
  input  logic                s_cfg_tvalid,
  input  logic                s_cfg_tlast,
  output logic                s_cfg_tready,
  input  logic [DATA_W-1:0]   s_dat_tdata,
  input  logic [DATA_W/8-1:0] s_dat_tkeep,
  input  logic [USER_W-1:0]   s_dat_tuser,
  input  logic                s_dat_tvalid,
  input  logic                s_dat_tlast,
  output logic                s_dat_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic [USER_W-1:0]   m_axis_tuser,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  input  logic                data_hold,
  output logic [CNT_W-1:0]    cfg_pkt_cnt,
  output logic [CNT_W-1:0]    dat_pkt_cnt,
  output logic                busy
);

  // Handshake: a beat moves on any port only in a cycle where tvalid and tready are both 1
  // at the rising clock edge; a source must hold its beat stable until that happens.

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    DAT  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [BURST_W-1:0]   burst_q;
  logic                 cfg_req;
  logic                 dat_req;
  logic                 burst_ok;
  logic                 out_free;
  logic                 cfg_acc;
  logic                 dat_acc;
  logic                 cfg_done;
  logic                 dat_done;

  assign cfg_req  = s_cfg_tvalid;
  assign dat_req  = s_dat_tvalid & ~data_hold;
  assign burst_ok = burst_q < BURST_W'(MAX_BURST);
  assign out_free = ~m_axis_tvalid | m_axis_tready;

  assign s_cfg_tready = (state_q == CFG) & out_free;
  assign s_dat_tready = (state_q == DAT) & out_free;
  assign cfg_acc      = s_cfg_tvalid & s_cfg_tready;
  assign dat_acc      = s_dat_tvalid & s_dat_tready;
  assign cfg_done     = cfg_acc & s_cfg_tlast;
  assign dat_done     = dat_acc & s_dat_tlast;
  assign busy         = (state_q != IDLE);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // Grants are decided only in IDLE, so a packet is never interleaved with another.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_req && (!dat_req || burst_ok)) state_d = CFG;
        else if (dat_req)                      state_d = DAT;
      end
      CFG:     if (cfg_done) state_d = IDLE;
      DAT:     if (dat_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (cfg_acc) begin
      m_axis_tdata  <= s_cfg_tdata;
      m_axis_tkeep  <= s_cfg_tkeep;
      m_axis_tuser  <= s_cfg_tuser;
      m_axis_tlast  <= s_cfg_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (dat_acc) begin
      m_axis_tdata  <= s_dat_tdata;
      m_axis_tkeep  <= s_dat_tkeep;
      m_axis_tuser  <= s_dat_tuser;
      m_axis_tlast  <= s_dat_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // The burst count only grows while data is actually waiting behind config traffic.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      cfg_pkt_cnt <= '0;
      dat_pkt_cnt <= '0;
      burst_q     <= '0;
    end else begin
      if (cfg_done) begin
        cfg_pkt_cnt <= cfg_pkt_cnt + 1'b1;
        if (s_dat_tvalid && !data_hold) begin
          if (burst_ok) burst_q <= burst_q + 1'b1;
        end else begin
          burst_q <= '0;
        end
      end
      if (dat_done) begin
        dat_pkt_cnt <= dat_pkt_cnt + 1'b1;
        burst_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_menshen_pkt_arbiter.sv
// Bench for menshen_pkt_arbiter: queue-driven sources, a packet-level reference model per port,
// and directed ordering scenarios plus a randomized stall/bubble run.
module tb_menshen_pkt_arbiter;

  localparam int DATA_W    = 64;
  localparam int USER_W    = 8;
  localparam int KEEP_W    = DATA_W / 8;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 16;
  localparam int BW        = USER_W + KEEP_W + DATA_W + 1;

  typedef logic [BW-1:0] beat_t;

  logic                axis_aclk;
  logic                axis_aresetn;
  logic [DATA_W-1:0]   s_cfg_tdata, s_dat_tdata, m_axis_tdata;
  logic [KEEP_W-1:0]   s_cfg_tkeep, s_dat_tkeep, m_axis_tkeep;
  logic [USER_W-1:0]   s_cfg_tuser, s_dat_tuser, m_axis_tuser;
  logic                s_cfg_tvalid, s_cfg_tlast, s_cfg_tready;
  logic                s_dat_tvalid, s_dat_tlast, s_dat_tready;
  logic                m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic                data_hold;
  logic [CNT_W-1:0]    cfg_pkt_cnt, dat_pkt_cnt;
  logic                busy;

  menshen_pkt_arbiter #(
    .DATA_W(DATA_W), .USER_W(USER_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
    .s_cfg_tdata(s_cfg_tdata), .s_cfg_tkeep(s_cfg_tkeep), .s_cfg_tuser(s_cfg_tuser),
    .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tlast(s_cfg_tlast), .s_cfg_tready(s_cfg_tready),
    .s_dat_tdata(s_dat_tdata), .s_dat_tkeep(s_dat_tkeep), .s_dat_tuser(s_dat_tuser),
    .s_dat_tvalid(s_dat_tvalid), .s_dat_tlast(s_dat_tlast), .s_dat_tready(s_dat_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .data_hold(data_hold), .cfg_pkt_cnt(cfg_pkt_cnt), .dat_pkt_cnt(dat_pkt_cnt), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    axis_aclk = 1'b0;
    forever #5 axis_aclk = ~axis_aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t src_cfg_q[$];
  beat_t src_dat_q[$];
  beat_t exp_cfg_q[$];
  beat_t exp_dat_q[$];
  logic  order_q[$];
  int    sent_cfg, sent_dat, pkt_id;
  int    bubble_pct;
  bit    rdy_rand, hold_rand, hold_mon;
  int    dat_rdy_in_hold;
  int    beats_seen;
  bit    in_pkt;
  logic  cur_port;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pkt(input logic port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      logic [KEEP_W-1:0] keep;
      logic [DATA_W-1:0] data;
      logic [USER_W-1:0] user;
      keep = ($urandom_range(9) == 0) ? '0 : KEEP_W'($urandom);
      data = {$urandom, $urandom};
      user = {port, (USER_W-1)'(pkt_id)};
      b = {user, keep, data, (i == len - 1)};
      if (port) begin src_dat_q.push_back(b); exp_dat_q.push_back(b); end
      else      begin src_cfg_q.push_back(b); exp_cfg_q.push_back(b); end
    end
    if (port) sent_dat++; else sent_cfg++;
    pkt_id++;
  endtask

  task automatic do_reset();
    axis_aresetn = 1'b0;
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tlast", m_axis_tlast, 1'b0);
    check("rst_m_tdata", m_axis_tdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_cnt", cfg_pkt_cnt, '0);
    check("rst_dat_cnt", dat_pkt_cnt, '0);
    check("rst_tready", {s_cfg_tready, s_dat_tready}, 2'b00);
    exp_cfg_q.delete();
    exp_dat_q.delete();
    order_q.delete();
    in_pkt   = 1'b0;
    sent_cfg = 0;
    sent_dat = 0;
    repeat (2) @(posedge axis_aclk);
    #3;
    axis_aresetn = 1'b1;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int cyc = 0;
    while (order_q.size() < n && cyc < budget) begin
      @(negedge axis_aclk);
      cyc++;
    end
    check("wait_pkts_done", order_q.size() >= n, 1'b1);
  endtask

  // Source drivers: present queued beats, keep a beat stable until accepted, optional bubbles.
  initial begin : drv_cfg
    logic acc;
    s_cfg_tvalid = 1'b0; s_cfg_tdata = '0; s_cfg_tkeep = '0; s_cfg_tuser = '0; s_cfg_tlast = 1'b0;
    forever begin
      @(negedge axis_aclk);
      acc = s_cfg_tvalid && s_cfg_tready;
      @(posedge axis_aclk);
      #1;
      if (!axis_aresetn) begin
        src_cfg_q.delete();
        s_cfg_tvalid = 1'b0;
      end else begin
        if (acc && src_cfg_q.size() > 0) void'(src_cfg_q.pop_front());
        if (!s_cfg_tvalid || acc) begin
          if (src_cfg_q.size() > 0 && $urandom_range(99) >= bubble_pct) begin
            s_cfg_tvalid = 1'b1;
            {s_cfg_tuser, s_cfg_tkeep, s_cfg_tdata, s_cfg_tlast} = src_cfg_q[0];
          end else begin
            s_cfg_tvalid = 1'b0;
          end
        end
      end
    end
  end

  initial begin : drv_dat
    logic acc;
    s_dat_tvalid = 1'b0; s_dat_tdata = '0; s_dat_tkeep = '0; s_dat_tuser = '0; s_dat_tlast = 1'b0;
    forever begin
      @(negedge axis_aclk);
      acc = s_dat_tvalid && s_dat_tready;
      @(posedge axis_aclk);
      #1;
      if (!axis_aresetn) begin
        src_dat_q.delete();
        s_dat_tvalid = 1'b0;
      end else begin
        if (acc && src_dat_q.size() > 0) void'(src_dat_q.pop_front());
        if (!s_dat_tvalid || acc) begin
          if (src_dat_q.size() > 0 && $urandom_range(99) >= bubble_pct) begin
            s_dat_tvalid = 1'b1;
            {s_dat_tuser, s_dat_tkeep, s_dat_tdata, s_dat_tlast} = src_dat_q[0];
          end else begin
            s_dat_tvalid = 1'b0;
          end
        end
      end
    end
  end

  initial begin : drv_sink
    m_axis_tready = 1'b1;
    forever begin
      @(posedge axis_aclk);
      #1;
      m_axis_tready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
      if (hold_rand) data_hold = ($urandom_range(9) == 0);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    beat_t cur, prev_beat;
    bit    prev_stall;
    logic  port;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge axis_aclk);
      if (!axis_aresetn) begin
        prev_stall = 1'b0;
        continue;
      end
      cur = {m_axis_tuser, m_axis_tkeep, m_axis_tdata, m_axis_tlast};
      if (prev_stall) begin
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_beat", cur, prev_beat);
      end
      if (hold_mon && data_hold && s_dat_tready) dat_rdy_in_hold++;
      if (m_axis_tvalid && m_axis_tready) begin
        port = m_axis_tuser[USER_W-1];
        beats_seen++;
        if (in_pkt) check("no_interleave", port, cur_port);
        in_pkt   = 1'b1;
        cur_port = port;
        if (port) begin
          check("dat_beat_expected", exp_dat_q.size() != 0, 1'b1);
          if (exp_dat_q.size() != 0) check("dat_beat", cur, exp_dat_q.pop_front());
        end else begin
          check("cfg_beat_expected", exp_cfg_q.size() != 0, 1'b1);
          if (exp_cfg_q.size() != 0) check("cfg_beat", cur, exp_cfg_q.pop_front());
        end
        if (m_axis_tlast) begin
          in_pkt = 1'b0;
          order_q.push_back(port);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur;
    end
  end

  // ---------------- test sequence ----------------
  initial begin : main
    int   cyc;
    logic burst_pat[8];
    axis_aresetn    = 1'b0;
    data_hold       = 1'b0;
    bubble_pct      = 0;
    rdy_rand        = 1'b0;
    hold_rand       = 1'b0;
    hold_mon        = 1'b0;
    dat_rdy_in_hold = 0;
    beats_seen      = 0;
    pkt_id          = 0;
    sent_cfg        = 0;
    sent_dat        = 0;

    // 1: single 2-beat cfg packet, latency and counters
    do_reset();
    @(negedge axis_aclk);
    send_pkt(1'b0, 2);
    cyc = 0;
    while (!s_cfg_tvalid && cyc < 20) begin @(negedge axis_aclk); cyc++; end
    cyc = 0;
    while (!m_axis_tvalid && cyc < 20) begin @(negedge axis_aclk); cyc++; end
    check("t1_latency", cyc, 2);
    wait_pkts(1, 100);
    check("t1_cfg_cnt", cfg_pkt_cnt, 1);
    check("t1_dat_cnt", dat_pkt_cnt, 0);
    check("t1_exp_empty", exp_cfg_q.size(), 0);

    // 2: simultaneous 3-beat requests, cfg first
    do_reset();
    @(negedge axis_aclk);
    send_pkt(1'b0, 3);
    send_pkt(1'b1, 3);
    wait_pkts(2, 200);
    check("t2_first", order_q[0], 1'b0);
    check("t2_second", order_q[1], 1'b1);
    check("t2_npkts", order_q.size(), 2);

    // 3: starvation guard, 6 cfg packets with data always pending
    do_reset();
    @(negedge axis_aclk);
    for (int i = 0; i < 6; i++) send_pkt(1'b0, $urandom_range(1, 3));
    send_pkt(1'b1, 2);
    send_pkt(1'b1, 2);
    burst_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    wait_pkts(8, 400);
    for (int i = 0; i < 8; i++) check($sformatf("t3_order_%0d", i), order_q[i], burst_pat[i]);

    // 4: data_hold blocks new data grants
    do_reset();
    @(negedge axis_aclk);
    data_hold = 1'b1;
    send_pkt(1'b1, 2);
    repeat (6) @(negedge axis_aclk);
    check("t4_idle_busy", busy, 1'b0);
    check("t4_no_output", order_q.size(), 0);
    hold_mon        = 1'b1;
    dat_rdy_in_hold = 0;
    send_pkt(1'b0, 2);
    wait_pkts(1, 100);
    repeat (4) @(negedge axis_aclk);
    check("t4_cfg_only", order_q[0], 1'b0);
    check("t4_one_pkt", order_q.size(), 1);
    check("t4_dat_rdy_held", dat_rdy_in_hold, 0);
    hold_mon  = 1'b0;
    data_hold = 1'b0;
    wait_pkts(2, 100);
    check("t4_dat_after", order_q[1], 1'b1);

    // 5: random traffic, stalls, bubbles and hold pulses
    do_reset();
    @(negedge axis_aclk);
    bubble_pct = 30;
    rdy_rand   = 1'b1;
    hold_rand  = 1'b1;
    for (int i = 0; i < 200; i++) send_pkt(1'($urandom_range(1)), $urandom_range(1, 4));
    wait_pkts(200, 30000);
    rdy_rand   = 1'b0;
    hold_rand  = 1'b0;
    bubble_pct = 0;
    @(negedge axis_aclk);
    data_hold = 1'b0;
    check("t5_cfg_drained", exp_cfg_q.size(), 0);
    check("t5_dat_drained", exp_dat_q.size(), 0);
    check("t5_cfg_cnt", cfg_pkt_cnt, CNT_W'(sent_cfg));
    check("t5_dat_cnt", dat_pkt_cnt, CNT_W'(sent_dat));

    // 6: reset in the middle of a 3-beat data packet
    do_reset();
    @(negedge axis_aclk);
    send_pkt(1'b0, 1);
    wait_pkts(1, 100);
    check("t6_pre_cfg_cnt", cfg_pkt_cnt, 1);
    beats_seen = 0;
    send_pkt(1'b1, 3);
    cyc = 0;
    while (beats_seen < 1 && cyc < 50) begin @(negedge axis_aclk); cyc++; end
    check("t6_midpkt", beats_seen, 1);
    #2;
    do_reset();
    @(negedge axis_aclk);
    check("t6_no_tvalid", m_axis_tvalid, 1'b0);
    send_pkt(1'b1, 3);
    wait_pkts(1, 100);
    check("t6_after_port", order_q[0], 1'b1);
    check("t6_dat_cnt", dat_pkt_cnt, 1);
    check("t6_cfg_cnt", cfg_pkt_cnt, 0);
    check("t6_exp_empty", exp_dat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
